// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Valid/ready command sequencer wrapped around a combinational
//                ALU, with result channel and chaining accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
  parameter int DWIDTH   = 8,
  parameter int CNTWIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_sel_i,
  input  logic [DWIDTH-1:0]   cmd_op1_i,
  input  logic [DWIDTH-1:0]   cmd_op2_i,
  input  logic                cmd_acc_i,
  output logic [1:0]          alu_sel_o,
  output logic [DWIDTH-1:0]   alu_op1_o,
  output logic [DWIDTH-1:0]   alu_op2_o,
  input  logic [DWIDTH-1:0]   alu_res_i,
  input  logic                alu_zero_i,
  input  logic                alu_neg_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [DWIDTH-1:0]   res_data_o,
  output logic                res_zero_o,
  output logic                res_neg_o,
  output logic [DWIDTH-1:0]   acc_o,
  output logic [CNTWIDTH-1:0] op_count_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [1:0]          r_sel;
  logic [DWIDTH-1:0]   r_op1;
  logic [DWIDTH-1:0]   r_op2;
  logic [DWIDTH-1:0]   r_res;
  logic                r_zero;
  logic                r_neg;
  logic [DWIDTH-1:0]   r_acc;
  logic [CNTWIDTH-1:0] r_count;
  logic                w_accept;
  logic                w_capture;
  logic                w_deliver;

  // Flush overrides every transition, including handshakes in the same cycle.
  assign w_accept  = (r_state == c_IDLE) & cmd_valid_i & ~flush_i;
  assign w_capture = (r_state == c_EXEC) & ~flush_i;
  assign w_deliver = (r_state == c_HOLD) & res_ready_i & ~flush_i;

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (cmd_valid_i) w_state_nxt = c_EXEC;
        c_EXEC:  w_state_nxt = c_HOLD;
        c_HOLD:  if (res_ready_i) w_state_nxt = c_IDLE;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand registers only change on accept, so the ALU inputs never glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
    end else if (w_accept) begin
      r_sel <= cmd_sel_i;
      r_op1 <= cmd_acc_i ? r_acc : cmd_op1_i;
      r_op2 <= cmd_op2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res  <= '0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_acc  <= '0;
    end else if (w_capture) begin
      r_res  <= alu_res_i;
      r_zero <= alu_zero_i;
      r_neg  <= alu_neg_i;
      r_acc  <= alu_res_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (w_deliver) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign cmd_ready_o = (r_state == c_IDLE);
  assign res_valid_o = (r_state == c_HOLD);
  assign alu_sel_o   = r_sel;
  assign alu_op1_o   = r_op1;
  assign alu_op2_o   = r_op2;
  assign res_data_o  = r_res;
  assign res_zero_o  = r_zero;
  assign res_neg_o   = r_neg;
  assign acc_o       = r_acc;
  assign op_count_o  = r_count;

endmodule
`default_nettype wire
